// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding modes, default field widths and the
// stage-1 payload carried between extraction and rounding.
package fpu_pkg;

  localparam int unsigned DEF_MAN_W = 23;
  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned KEPT_W    = DEF_MAN_W + 1;
  localparam int unsigned PEXP_W    = DEF_EXP_W + 2;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  // Payload fields are sized for the default format
  typedef struct packed {
    logic [KEPT_W-1:0] kept;
    logic              l;
    logic              g;
    logic              s;
    logic [PEXP_W-1:0] exp;
    logic              sign;
    rmode_e            rmode;
    logic              err;
  } s1_payload_t;

  // Round-increment decision from LSB/guard/sticky and sign
  function automatic logic round_inc(input rmode_e rm, input logic l, input logic g,
                                     input logic s, input logic sign);
    logic inc;
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (s | l);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (g | s) & ~sign;
      RM_RDN:  inc = (g | s) & sign;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_round_unit_if.sv
// Valid/ready bus between the significand multiplier, the rounding unit
// and result packing.
interface fp_round_unit_if #(
  parameter int unsigned MAN_W = fpu_pkg::DEF_MAN_W,
  parameter int unsigned EXP_W = fpu_pkg::DEF_EXP_W
);
  localparam int unsigned PROD_W = 2 * MAN_W + 2;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic [EXP_W:0]    exp_in;
  logic              sign_in;
  logic [1:0]        rmode;
  logic              rerror;
  logic              out_valid;
  logic              out_ready;
  logic [MAN_W-1:0]  man_out;
  logic [EXP_W-1:0]  exp_out;
  logic              sign_out;
  logic              inexact;
  logic              overflow;
  logic              err_out;

  modport master (
    output in_valid, product, exp_in, sign_in, rmode, rerror, out_ready,
    input  in_ready, out_valid, man_out, exp_out, sign_out, inexact, overflow, err_out
  );

  modport slave (
    input  in_valid, product, exp_in, sign_in, rmode, rerror, out_ready,
    output in_ready, out_valid, man_out, exp_out, sign_out, inexact, overflow, err_out
  );

endinterface

// File: rtl/fp_grs_extract.sv
// Normalisation-shift detection and LSB/guard/sticky extraction from the
// raw significand product.
module fp_grs_extract
  import fpu_pkg::*;
#(
  parameter  int unsigned MAN_W  = DEF_MAN_W,
  localparam int unsigned PROD_W = 2 * MAN_W + 2
) (
  input  logic [PROD_W-1:0] product,
  output logic              shift_c,
  output logic [MAN_W:0]    kept_c,
  output logic              l_c,
  output logic              g_c,
  output logic              s_c
);

  always_comb begin
    shift_c = product[PROD_W-1];
    kept_c  = '0;
    l_c     = 1'b0;
    g_c     = 1'b0;
    s_c     = 1'b0;
    if (shift_c) begin
      kept_c = product[PROD_W-1:MAN_W+1];
      l_c    = product[MAN_W+1];
      g_c    = product[MAN_W];
      s_c    = |product[MAN_W-1:0];
    end else begin
      kept_c = product[PROD_W-2:MAN_W];
      l_c    = product[MAN_W];
      g_c    = product[MAN_W-1];
      s_c    = |product[MAN_W-2:0];
    end
  end

endmodule

// File: rtl/fp_round_unit.sv
// Two-stage rounding unit for the multiply path: extract L/G/S, round,
// renormalise and flag. FP_ROUND_MODES_EN enables per-beat rmode selection.
module fp_round_unit
  import fpu_pkg::*;
#(
  parameter int unsigned MAN_W = DEF_MAN_W,
  parameter int unsigned EXP_W = DEF_EXP_W
) (
  input  logic          clk,
  input  logic          rst,
  fp_round_unit_if.slave bus
);

  localparam int unsigned SUM_W  = MAN_W + 2;
  localparam int unsigned EXPX_W = EXP_W + 2;
  localparam logic [EXPX_W-1:0] EXP_INF = EXPX_W'((1 << EXP_W) - 1);

  logic             shift_c;
  logic [MAN_W:0]   kept_c;
  logic             l_c;
  logic             g_c;
  logic             s_c;

  s1_payload_t      s1_d;
  s1_payload_t      s1_q;
  logic             s1_v;
  logic             adv;

  logic [MAN_W:0]   kept2;
  logic             inc;
  logic [SUM_W-1:0] sum;
  logic             carry;
  logic             unused_hidden;
  logic [MAN_W-1:0] man_sum;
  logic [EXPX_W-1:0] exp_f;
  logic [MAN_W-1:0] man_d;
  logic [EXP_W-1:0] exp_d;
  logic             inx_d;
  logic             ovf_d;
  logic             err_d;

  logic             out_valid_q;
  logic [MAN_W-1:0] man_q;
  logic [EXP_W-1:0] exp_q;
  logic             sign_q;
  logic             inx_q;
  logic             ovf_q;
  logic             err_q;

  fp_grs_extract #(.MAN_W(MAN_W)) u_grs (
    .product (bus.product),
    .shift_c (shift_c),
    .kept_c  (kept_c),
    .l_c     (l_c),
    .g_c     (g_c),
    .s_c     (s_c)
  );

  // Whole pipe advances together; a stalled output freezes both stages
  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    s1_d       = '0;
    s1_d.kept  = KEPT_W'(kept_c);
    s1_d.l     = l_c;
    s1_d.g     = g_c;
    s1_d.s     = s_c;
    s1_d.exp   = PEXP_W'(EXPX_W'(bus.exp_in) + EXPX_W'(shift_c));
    s1_d.sign  = bus.sign_in;
    s1_d.err   = bus.rerror;
`ifdef FP_ROUND_MODES_EN
    s1_d.rmode = rmode_e'(bus.rmode);
`else
    s1_d.rmode = RM_RNE;
`endif
  end

`ifndef FP_ROUND_MODES_EN
  logic unused_rmode;
  assign unused_rmode = ^bus.rmode;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (adv) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  // Round, renormalise on carry-out, then saturate to infinity
  always_comb begin
    kept2 = (MAN_W + 1)'(s1_q.kept);
    inc   = round_inc(s1_q.rmode, s1_q.l, s1_q.g, s1_q.s, s1_q.sign);
    sum   = SUM_W'(kept2) + SUM_W'(inc);
    {carry, unused_hidden, man_sum} = sum;
    exp_f = EXPX_W'(s1_q.exp) + EXPX_W'(carry);
    man_d = '0;
    exp_d = '0;
    inx_d = 1'b0;
    ovf_d = 1'b0;
    err_d = 1'b0;
    if (s1_q.err) begin
      err_d = 1'b1;
    end else if (exp_f >= EXP_INF) begin
      exp_d = '1;
      inx_d = 1'b1;
      ovf_d = 1'b1;
    end else begin
      man_d = man_sum;
      exp_d = exp_f[EXP_W-1:0];
      inx_d = s1_q.g | s1_q.s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      man_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      inx_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_v;
      if (s1_v) begin
        man_q  <= man_d;
        exp_q  <= exp_d;
        sign_q <= s1_q.sign;
        inx_q  <= inx_d;
        ovf_q  <= ovf_d;
        err_q  <= err_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.man_out   = man_q;
  assign bus.exp_out   = exp_q;
  assign bus.sign_out  = sign_q;
  assign bus.inexact   = inx_q;
  assign bus.overflow  = ovf_q;
  assign bus.err_out   = err_q;

endmodule
